// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared encodings and defaults for the UART program loader
//
// Purpose : receiver and loader state encodings plus default parameter values.
// Ports   : none (package).
// Config  : LOADER_CHECKSUM_EN adds the L_CHK loader state.
package prog_loader_pkg;

  localparam int DEF_CLKS_PER_BIT = 434;
  localparam int DEF_WORDS        = 64;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {
    L_HI   = 2'd0,
    L_LO   = 2'd1,
    L_DONE = 2'd2,
    L_CHK  = 2'd3
  } ld_state_e;
`else
  typedef enum logic [1:0] {
    L_HI   = 2'd0,
    L_LO   = 2'd1,
    L_DONE = 2'd2
  } ld_state_e;
`endif

endpackage

// File: rtl/prog_loader_uart_rx_byte.sv
// rtl/prog_loader_uart_rx_byte.sv - 8N1 UART byte receiver with sticky framing error
//
// Purpose : synchronizes rx, finds the start bit, samples 8 data bits LSB first
//           mid-bit and checks the stop bit.
// Ports   : clock, reset (sync, active high), rx (async serial in, idle high),
//           data_byte[7:0] (last received byte), byte_valid (1-cycle strobe),
//           frame_err (sticky, set on a bad stop bit).
module uart_rx_byte
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CW   = $clog2(CLKS_PER_BIT + 1);
  // Half-bit delay lands the samples mid-bit; never zero so START always waits.
  localparam int HALF = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;

  rx_state_e   state_q, state_d;
  logic        sync1_q, sync2_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    valid_d = 1'b0;
    ferr_d  = ferr_q;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        // Edge rather than level: a line left low by a bad stop bit must not
        // look like a new start bit.
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          shreg_d = {sync2_q, shreg_q[7:1]};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (sync2_q) valid_d = 1'b1;
          else         ferr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // shreg only shifts in DATA, so it still holds the byte when valid pulses.
  assign data_byte  = shreg_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - loads WORDS 16-bit words from a UART into program memory
//
// Purpose : assembles received bytes (high byte first) into words, writes them
//           to consecutive addresses from 0 and releases the CPU when done.
// Ports   : clock, reset (sync, active high), rx (UART in), mem_addr[5:0],
//           mem_data[15:0], mem_we (1-cycle strobe), cpu_hold, load_done,
//           frame_err (sticky).
// Config  : LOADER_CHECKSUM_EN - after the last word a checksum byte (XOR of
//           all data bytes) must match before load_done; a mismatch restarts.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int WORDS        = DEF_WORDS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  output logic [5:0]  mem_addr,
  output logic [15:0] mem_data,
  output logic        mem_we,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        frame_err
);

  logic [7:0] rx_byte;
  logic       rx_byte_valid;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .data_byte  (rx_byte),
    .byte_valid (rx_byte_valid),
    .frame_err  (frame_err)
  );

  ld_state_e   ld_state_q, ld_state_d;
  logic [5:0]  addr_q, addr_d;
  logic [7:0]  hi_q, hi_d;
  logic [5:0]  mem_addr_q, mem_addr_d;
  logic [15:0] mem_data_q, mem_data_d;
  logic        mem_we_q, mem_we_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  cs_q, cs_d;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      ld_state_q <= L_HI;
      addr_q     <= '0;
      hi_q       <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      cs_q       <= '0;
`endif
    end else begin
      ld_state_q <= ld_state_d;
      addr_q     <= addr_d;
      hi_q       <= hi_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
`ifdef LOADER_CHECKSUM_EN
      cs_q       <= cs_d;
`endif
    end
  end

  always_comb begin
    ld_state_d = ld_state_q;
    addr_d     = addr_q;
    hi_d       = hi_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    cs_d       = cs_q;
`endif
    case (ld_state_q)
      L_HI: begin
        if (rx_byte_valid) begin
          hi_d       = rx_byte;
          ld_state_d = L_LO;
`ifdef LOADER_CHECKSUM_EN
          cs_d       = cs_q ^ rx_byte;
`endif
        end
      end
      L_LO: begin
        if (rx_byte_valid) begin
          // Address/data register together with the strobe, so both are
          // stable for the whole write and until the next one.
          mem_data_d = {hi_q, rx_byte};
          mem_addr_d = addr_q;
          mem_we_d   = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          cs_d       = cs_q ^ rx_byte;
`endif
          if (addr_q == 6'(WORDS - 1)) begin
            // Last word: leave the counter put so it can never wrap.
`ifdef LOADER_CHECKSUM_EN
            ld_state_d = L_CHK;
`else
            ld_state_d = L_DONE;
`endif
          end else begin
            addr_d     = addr_q + 1'b1;
            ld_state_d = L_HI;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      L_CHK: begin
        if (rx_byte_valid) begin
          if (rx_byte == cs_q) begin
            ld_state_d = L_DONE;
          end else begin
            ld_state_d = L_HI;
            addr_d     = '0;
            mem_addr_d = '0;
            cs_d       = '0;
          end
        end
      end
`endif
      L_DONE: ld_state_d = L_DONE;
      default: ld_state_d = L_HI;
    endcase
  end

  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign mem_we    = mem_we_q;
  assign load_done = (ld_state_q == L_DONE);
  assign cpu_hold  = (ld_state_q != L_DONE);

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader (CLKS_PER_BIT=4, WORDS=2)
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int CPB = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx    = 1'b1;
  logic [5:0]  mem_addr;
  logic [15:0] mem_data;
  logic        mem_we;
  logic        cpu_hold;
  logic        load_done;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int bv_count = 0;
  logic prev_we = 1'b0;

  logic [21:0] wq[$];   // expected writes {addr, data}
  logic [7:0]  bq[$];   // expected received bytes

  prog_loader #(.CLKS_PER_BIT(CPB), .WORDS(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_we    (mem_we),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .frame_err (frame_err)
  );

  always #5 clock = ~clock;

  // Monitor: pops expectations whenever the DUT presents a write or a byte.
  always @(negedge clock) begin
    logic [21:0] ew;
    logic [7:0]  eb;
    if (mem_we) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%0d data=%h required none", mem_addr, mem_data);
      end else begin
        ew = wq.pop_front();
        if ({mem_addr, mem_data} !== ew) begin
          errors++;
          $display("FAIL write got addr=%0d data=%h required addr=%0d data=%h",
                   mem_addr, mem_data, ew[21:16], ew[15:0]);
        end
      end
      checks++;
      if (prev_we) begin
        errors++;
        $display("FAIL we_width got mem_we high 2+ cycles required 1");
      end
    end
    prev_we = mem_we;
    if (dut.rx_byte_valid) begin
      bv_count++;
      checks++;
      if (bq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte got %h required none", dut.rx_byte);
      end else begin
        eb = bq.pop_front();
        if (dut.rx_byte !== eb) begin
          errors++;
          $display("FAIL rx_byte got %h required %h", dut.rx_byte, eb);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", name, act, exp);
    end
  endtask

  task automatic hold_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clock);
  endtask

  // Start bit, nbits data bits LSB first, optional stop bit, then idle.
  task automatic send_bits(input logic [7:0] b, input int nbits, input bit do_stop, input logic stop_v);
    @(negedge clock);
    hold_bit(1'b0);
    for (int i = 0; i < nbits; i++) hold_bit(b[i]);
    if (do_stop) begin
      hold_bit(stop_v);
      hold_bit(1'b1);
      hold_bit(1'b1);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bq.push_back(b);
    send_bits(b, 8, 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"},  32'(mem_addr),  32'h0);
    chk({tag, "_data"},  32'(mem_data),  32'h0);
    chk({tag, "_we"},    32'(mem_we),    32'h0);
    chk({tag, "_hold"},  32'(cpu_hold),  32'h1);
    chk({tag, "_done"},  32'(load_done), 32'h0);
    chk({tag, "_ferr"},  32'(frame_err), 32'h0);
  endtask

  task automatic full_load();
    wq.push_back({6'd0, 16'h1234});
    wq.push_back({6'd1, 16'hABCD});
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'hAB);
    send_byte(8'hCD);
  endtask

  initial begin
    int bv_before;
    do_reset();
    chk_reset_vals("reset");

    // Main load.
    full_load();
`ifdef LOADER_CHECKSUM_EN
    chk("pre_cs_done", 32'(load_done), 32'h0);
    send_byte(8'h40);
`endif
    chk("load_done", 32'(load_done), 32'h1);
    chk("cpu_hold",  32'(cpu_hold),  32'h0);

    // Bytes after completion are ignored.
    send_byte(8'hFF);
    send_byte(8'hFF);
    chk("ignore_addr", 32'(mem_addr),  32'h1);
    chk("ignore_data", 32'(mem_data),  32'hABCD);
    chk("ignore_done", 32'(load_done), 32'h1);
    chk("ignore_hold", 32'(cpu_hold),  32'h0);

    // One-cycle glitch is rejected; next byte is still received.
    do_reset();
    bv_before = bv_count;
    @(negedge clock);
    rx = 1'b0;
    @(negedge clock);
    rx = 1'b1;
    repeat (12) @(negedge clock);
    chk("glitch_rx_idle", 32'(dut.u_rx.state_q), 32'(RX_IDLE));
    chk("glitch_no_byte", 32'(bv_count - bv_before), 32'h0);
    wq.push_back({6'd0, 16'h5A5B});
    send_byte(8'h5A);
    send_byte(8'h5B);

    // Framing error: sticky flag, byte discarded, loader not advanced.
    do_reset();
    send_bits(8'h77, 8, 1'b1, 1'b0);
    chk("ferr_set",   32'(frame_err), 32'h1);
    chk("ferr_state", 32'(dut.ld_state_q), 32'(L_HI));
    wq.push_back({6'd0, 16'h1234});
    send_byte(8'h12);
    send_byte(8'h34);
    chk("ferr_sticky", 32'(frame_err), 32'h1);

    // Reset mid-word and mid-byte, then a fresh load from address 0.
    send_byte(8'h12);
    send_bits(8'h34, 3, 1'b0, 1'b1);
    do_reset();
    chk_reset_vals("midreset");
    repeat (2 * CPB) @(negedge clock);
    full_load();
`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum restarts the load.
    send_byte(8'h41);
    chk("badcs_done", 32'(load_done), 32'h0);
    chk("badcs_hold", 32'(cpu_hold),  32'h1);
    chk("badcs_addr", 32'(mem_addr),  32'h0);
    chk("badcs_state", 32'(dut.ld_state_q), 32'(L_HI));
`else
    chk("reload_done", 32'(load_done), 32'h1);
`endif

    repeat (4 * CPB) @(negedge clock);
    chk("writes_drained", 32'(wq.size()), 32'h0);
    chk("bytes_drained",  32'(bq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The module SHALL take parameter CLKS_PER_BIT, default 434, meaning clock cycles per UART bit (50 MHz / 115200 baud).
REQ-002 The module SHALL take parameter WORDS, default 64, meaning the number of 16-bit words loaded (1..64).
REQ-003 The module SHALL have port clock, input, 1 bit: the single clock, rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port rx, input, 1 bit: asynchronous UART serial input, 8N1, idle high.
REQ-006 The module SHALL have port mem_addr, output, 6 bits: word address into program memory.
REQ-007 The module SHALL have port mem_data, output, 16 bits: word to be written.
REQ-008 The module SHALL have port mem_we, output, 1 bit: one-cycle memory write strobe.
REQ-009 The module SHALL have port cpu_hold, output, 1 bit: holds the CPU in state 0 while high.
REQ-010 The module SHALL have port load_done, output, 1 bit: all WORDS words have been written.
REQ-011 The module SHALL have port frame_err, output, 1 bit: sticky flag, set when a stop bit is bad.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; both flops reset to 1.
REQ-013 The receiver FSM SHALL have states IDLE, START, DATA and STOP.
REQ-014 IDLE->START on the synchronized rx falling edge.
REQ-015 START SHALL wait CLKS_PER_BIT/2 cycles, then go to DATA if rx=0, or back to IDLE if rx=1 (glitch rejected).
REQ-016 DATA SHALL sample 8 bits, LSB first, each CLKS_PER_BIT cycles after the previous sample.
REQ-017 STOP SHALL sample once after CLKS_PER_BIT cycles. If rx=1 it pulses byte_valid for 1 cycle. If rx=0 it sets frame_err and discards the byte. Either way it returns to IDLE.
REQ-018 The loader FSM SHALL have states L_HI, L_LO and L_DONE, plus L_CHK when LOADER_CHECKSUM_EN is defined.
REQ-019 In L_HI, byte_valid SHALL latch the byte into the high half and move to L_LO.
REQ-020 In L_LO, byte_valid SHALL drive mem_data={hi,byte} and mem_addr=current address, and assert mem_we the next cycle for exactly 1 cycle.
REQ-021 After the L_LO write, the address SHALL increment. If the address was WORDS-1, the FSM goes to L_DONE (or L_CHK); otherwise it returns to L_HI.
REQ-022 mem_addr and mem_data SHALL remain stable while mem_we is high and until the next write.
REQ-023 A discarded (framing-error) byte SHALL NOT advance the loader FSM.
REQ-024 In L_DONE, load_done=1 and cpu_hold=0, and all further bytes SHALL be ignored until reset.
REQ-025 The address SHALL never wrap. Address 63 SHALL be the final word when WORDS=64.
REQ-026 If byte_valid and reset occur in the same cycle, reset SHALL win.

Reset
REQ-027 On reset the module SHALL set receiver=IDLE, loader=L_HI, mem_addr=0, mem_data=0, mem_we=0, cpu_hold=1, load_done=0, frame_err=0, and clear the checksum.
REQ-028 Reset mid-byte or mid-word SHALL abandon the partial data; loading restarts at address 0.

Configuration
REQ-029 With LOADER_CHECKSUM_EN defined, the loader SHALL keep a running XOR of all received data bytes. After the last word it enters L_CHK and the next byte is compared with the XOR.
REQ-030 With LOADER_CHECKSUM_EN defined, a checksum match SHALL go to L_DONE. A mismatch SHALL return to L_HI with address 0 and the checksum cleared, keeping cpu_hold=1.
REQ-031 Without LOADER_CHECKSUM_EN, L_CHK SHALL not exist and L_DONE SHALL follow the last word directly.

Structure
REQ-032 A shared package SHALL hold the receiver and loader state encodings and the default constants 434 and 64.
REQ-033 The receiver SHALL be the sub-module uart_rx_byte: synchronizer, receiver FSM, bit counter and baud counter, with byte[7:0], byte_valid and frame_err outputs.
REQ-034 prog_loader SHALL contain the loader FSM, the address counter and the checksum.

Verification
REQ-035 The bench SHALL use CLKS_PER_BIT=4 and WORDS=2.
REQ-036 Send bytes 0x12,0x34,0xAB,0xCD -> mem_we pulses with (addr 0, data 0x1234) and (addr 1, data 0xABCD); then load_done=1 and cpu_hold=0.
REQ-037 Drive a 1-cycle low glitch on rx -> no byte_valid, receiver back in IDLE, and the next byte 0x5A is received correctly.
REQ-038 Send byte 0x77 with stop bit=0 -> frame_err=1 and no state advance; then 0x12,0x34 -> write of 0x1234 at addr 0.
REQ-039 Assert reset after 0x12 and 3 bits of 0x34 -> all outputs at reset values; a fresh 4-byte load writes addr 0 first.
REQ-040 With LOADER_CHECKSUM_EN: 0x12,0x34,0xAB,0xCD then checksum 0x40 -> load_done=1. With checksum 0x41 instead -> load_done=0, cpu_hold=1, address 0.
REQ-041 After load_done, send 0xFF,0xFF -> no mem_we and outputs unchanged.
